text_console_ctrl: RTL and testbench

TEXT_CONSOLE_CTRL -- requirements
Module: text_console_ctrl

---
 rtl/text_console_pkg.sv | 28 ++
 rtl/text_console_if.sv | 9 +
 rtl/text_console_addr.sv | 32 +++
 rtl/text_console_ctrl.sv | 142 ++++++++++++++
 tb/tb_text_console_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/text_console_pkg.sv
// Shared defaults, FSM state encoding and control codes for the text console controller.
package text_console_pkg;

  localparam int DEF_COLS  = 80;
  localparam int DEF_ROWS  = 30;
  localparam int DEF_CELLS = DEF_COLS * DEF_ROWS;
  localparam logic [7:0] DEF_BLANK = 8'h20;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 7;
  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CLEAR      = 2'd1,
    ST_SCROLL_CLR = 2'd2
  } state_e;

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/text_console_if.sv
// Character stream handshake between a producer (master) and the console controller (slave).
interface text_console_if;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;

  modport master (output char_valid, output char_data, input char_ready);
  modport slave  (input char_valid, input char_data, output char_ready);
endinterface

// File: rtl/text_console_addr.sv
// Combinational screen (top_row,row,col) to physical text RAM address mapping.
module text_console_addr
  import text_console_pkg::*;
#(
  parameter int COLS = DEF_COLS,
  parameter int ROWS = DEF_ROWS
) (
  input  logic [ROW_W-1:0]  top_row,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [7:0] COLS_BITS = 8'(COLS);

  logic [ROW_W:0]    row_sum;
  logic [ROW_W-1:0]  phys_row;
  logic [ADDR_W-1:0] acc;

  always_comb begin
    row_sum  = (ROW_W+1)'(top_row) + (ROW_W+1)'(row);
    phys_row = (row_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(row_sum - (ROW_W+1)'(ROWS))
                                              : ROW_W'(row_sum);
    // COLS is a constant, so this collapses to a fixed shift-add tree
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (COLS_BITS[i]) acc = acc + (ADDR_W'(phys_row) << i);
    end
    addr = acc + ADDR_W'(col);
  end

endmodule

// File: rtl/text_console_ctrl.sv
// Text console write controller: cursor tracking, scrolling and screen clear into a text RAM.
// Optional macro TEXT_CONSOLE_CURSOR_EN adds the registered cursor_addr output.
//
// state      | meaning
// IDLE       | accepting characters, single-cycle writes of printables
// CLEAR      | blanking every cell 0..CELLS-1, one per cycle
// SCROLL_CLR | blanking the COLS cells of the new bottom physical row
module text_console_ctrl
  import text_console_pkg::*;
#(
  parameter int          COLS  = DEF_COLS,
  parameter int          ROWS  = DEF_ROWS,
  parameter logic [7:0]  BLANK = DEF_BLANK
) (
  input  logic              clk,
  input  logic              rst_n,
  text_console_if.slave     cif,
  output logic              we,
  output logic [ADDR_W-1:0] wraddr,
  output logic [7:0]        wrdata,
  output logic [ROW_W-1:0]  top_row,
  output logic              busy
`ifdef TEXT_CONSOLE_CURSOR_EN
  ,
  output logic [ADDR_W-1:0] cursor_addr
`endif
);

  localparam int CELLS = COLS * ROWS;

  localparam logic [1:0] S_IDLE       = ST_IDLE;
  localparam logic [1:0] S_CLEAR      = ST_CLEAR;
  localparam logic [1:0] S_SCROLL_CLR = ST_SCROLL_CLR;

  logic [1:0]        state;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [ADDR_W-1:0] sweep_addr;
  logic [ADDR_W-1:0] sweep_left;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] scroll_base;
  logic [ROW_W-1:0]  top_next;
  logic              accept;
  logic              printable;
  logic              nl;

  text_console_addr #(.COLS(COLS), .ROWS(ROWS)) u_addr_cur (
    .top_row (top_row),
    .row     (row),
    .col     (col),
    .addr    (cur_addr)
  );

  // After the scroll the old top physical row becomes the new bottom row
  text_console_addr #(.COLS(COLS), .ROWS(ROWS)) u_addr_base (
    .top_row (top_row),
    .row     ('0),
    .col     ('0),
    .addr    (scroll_base)
  );

  assign cif.char_ready = (state == S_IDLE);
  assign busy           = !cif.char_ready;

  always_comb begin
    accept    = cif.char_valid && cif.char_ready;
    printable = is_printable(cif.char_data);
    nl        = accept && ((printable && (col == COL_W'(COLS-1))) ||
                           (cif.char_data == CC_LF));
    top_next  = (top_row == ROW_W'(ROWS-1)) ? '0 : top_row + ROW_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      sweep_addr <= '0;
      sweep_left <= ADDR_W'(CELLS-1);
      row        <= '0;
      col        <= '0;
      top_row    <= '0;
      we         <= 1'b0;
      wraddr     <= '0;
      wrdata     <= '0;
    end else begin
      we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (printable) begin
              we     <= 1'b1;
              wraddr <= cur_addr;
              wrdata <= cif.char_data;
              if (!nl) col <= col + COL_W'(1);
            end else begin
              case (cif.char_data)
                CC_CR: col <= '0;
                CC_BS: if (col != '0) col <= col - COL_W'(1);
                CC_FF: begin
                  row        <= '0;
                  col        <= '0;
                  top_row    <= '0;
                  state      <= S_CLEAR;
                  sweep_addr <= '0;
                  sweep_left <= ADDR_W'(CELLS-1);
                end
                default: ;
              endcase
            end
            if (nl) begin
              col <= '0;
              if (row != ROW_W'(ROWS-1)) begin
                row <= row + ROW_W'(1);
              end else begin
                top_row    <= top_next;
                state      <= S_SCROLL_CLR;
                sweep_addr <= scroll_base;
                sweep_left <= ADDR_W'(COLS-1);
              end
            end
          end
        end
        S_CLEAR, S_SCROLL_CLR: begin
          we         <= 1'b1;
          wraddr     <= sweep_addr;
          wrdata     <= BLANK;
          sweep_addr <= sweep_addr + ADDR_W'(1);
          sweep_left <= sweep_left - ADDR_W'(1);
          if (sweep_left == '0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef TEXT_CONSOLE_CURSOR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cursor_addr <= '0;
    else        cursor_addr <= cur_addr;
  end
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed self-checking bench for text_console_ctrl (80x30 defaults).
module tb_text_console_ctrl;

  localparam logic [7:0] BLANK = 8'h20;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [11:0] wraddr;
  logic [7:0]  wrdata;
  logic [4:0]  top_row;
  logic        busy;
`ifdef TEXT_CONSOLE_CURSOR_EN
  logic [11:0] cursor_addr;
`endif

  int n_chk = 0;
  int n_err = 0;

  text_console_if cif();

  text_console_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cif     (cif),
    .we      (we),
    .wraddr  (wraddr),
    .wrdata  (wrdata),
    .top_row (top_row),
    .busy    (busy)
`ifdef TEXT_CONSOLE_CURSOR_EN
    ,
    .cursor_addr (cursor_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the handshake edge.
  task automatic send(input logic [7:0] c);
    int n;
    n = 0;
    cif.char_valid = 1'b1;
    cif.char_data  = c;
    while (!cif.char_ready && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", 32'(cif.char_ready), 1);
    @(posedge clk); #1;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'hFF;
  endtask

  // Expects n consecutive blank writes from base starting at the next edge.
  task automatic sweep_check(input string tag, input int base, input int n);
    int errs;
    errs = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (!(we === 1'b1 && wraddr === 12'(base + k) && wrdata === BLANK)) errs++;
      if (k < n - 1 && cif.char_ready !== 1'b0) errs++;
    end
    check(tag, 32'(errs), 0);
    check({tag, "_ready"}, 32'(cif.char_ready), 1);
  endtask

  initial begin
    int errs;
    rst_n          = 1'b0;
    cif.char_valid = 1'b0;
    cif.char_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_we", 32'(we), 0);
    check("rst_wraddr", 32'(wraddr), 0);
    check("rst_wrdata", 32'(wrdata), 0);
    check("rst_top_row", 32'(top_row), 0);
    check("rst_ready", 32'(cif.char_ready), 0);
    check("rst_busy", 32'(busy), 1);
`ifdef TEXT_CONSOLE_CURSOR_EN
    check("rst_cursor", 32'(cursor_addr), 0);
`endif
    rst_n = 1'b1;
    sweep_check("init_clear", 0, 2400);

    send(8'h41);
    check("A_we", 32'(we), 1);
    check("A_addr", 32'(wraddr), 0);
    check("A_data", 32'(wrdata), 32'h41);
    send(8'h42);
    check("B_we", 32'(we), 1);
    check("B_addr", 32'(wraddr), 1);
    check("B_data", 32'(wrdata), 32'h42);
    @(posedge clk); #1;
    check("B_we_drop", 32'(we), 0);
`ifdef TEXT_CONSOLE_CURSOR_EN
    check("B_cursor", 32'(cursor_addr), 2);
`endif

    send(8'h0D);
    check("cr_nowrite", 32'(we), 0);
    send(8'h0A);
    check("lf_nowrite", 32'(we), 0);
    send(8'h43);
    check("C_addr", 32'(wraddr), 80);
    check("C_data", 32'(wrdata), 32'h43);
    send(8'h44);
    check("D_addr", 32'(wraddr), 81);
    send(8'h08);
    check("bs_nowrite", 32'(we), 0);
    send(8'h45);
    check("E_after_bs", 32'(wraddr), 81);
    send(8'h07);
    check("bell_dropped", 32'(we), 0);
    send(8'h0D);
    send(8'h08);
    send(8'h46);
    check("bs_at_col0", 32'(wraddr), 80);

    // Walk down to the bottom row and fill 79 columns
    for (int k = 0; k < 28; k++) send(8'h0A);
    check("row29_top", 32'(top_row), 0);
    send(8'h0D);
    errs = 0;
    for (int k = 0; k < 79; k++) begin
      send(8'h78);
      if (!(we === 1'b1 && wraddr === 12'(2320 + k))) errs++;
    end
    check("bottom_fill", 32'(errs), 0);
    send(8'h0A);
    check("scroll_lf_we", 32'(we), 0);
    check("scroll_lf_ready", 32'(cif.char_ready), 0);
    check("scroll_top1", 32'(top_row), 1);
    sweep_check("scroll0", 0, 80);
    send(8'h47);
    check("G_wrapped_addr", 32'(wraddr), 0);
    for (int k = 0; k < 78; k++) send(8'h79);
    send(8'h77);
    check("wrap_write_addr", 32'(wraddr), 79);
    check("wrap_write_data", 32'(wrdata), 32'h77);
    check("wrap_ready", 32'(cif.char_ready), 0);
    sweep_check("scroll1", 80, 80);
    check("scroll_top2", 32'(top_row), 2);
    for (int j = 2; j < 5; j++) begin
      send(8'h0A);
      sweep_check("scroll_n", j * 80, 80);
    end
    check("scroll_top5", 32'(top_row), 5);

    send(8'h0C);
    check("ff_top0", 32'(top_row), 0);
    check("ff_ready", 32'(cif.char_ready), 0);
    sweep_check("ff_clear", 0, 2400);
    send(8'h5A);
    check("Z_addr", 32'(wraddr), 0);
    check("Z_data", 32'(wrdata), 32'h5A);

    // Reset in the middle of a clear
    send(8'h0C);
    repeat (1000) begin
      @(posedge clk); #1;
    end
    check("mid_clear_addr", 32'(wraddr), 999);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(we), 0);
    check("midrst_addr", 32'(wraddr), 0);
    check("midrst_busy", 32'(busy), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sweep_check("restart_clear", 0, 2400);
    send(8'h51);
    check("Q_addr", 32'(wraddr), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
